rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
Four-requester round-robin arbiter and sequencer for one shared datapath resource, such as a register write port or a memory/bus port. It grants exactly one requester at a time and holds the grant until the resource signals completion. It drives the select of the shared input mux internally, so the resource sees one WIDTH-bit operand. It sits between the requesting units and the shared register/mux datapath.

Parameters:
WIDTH, 16, width of each requester data input and of dout
TIMEOUT, 16, maximum grant length in cycles when ARB_TIMEOUT_EN is defined; legal range 1..255

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  4  request lines; bit i = requester i
done  input  1  resource finished the current transaction; sampled only while busy
din0, din1, din2, din3  input  WIDTH  requester data
gnt  output  4  registered one-hot grant; 0 when idle
gsel  output  2  registered binary index of granted requester
busy  output  1  registered; 1 while a grant is held
start  output  1  registered; 1 only on the first cycle of each grant
dout  output  WIDTH  din selected by gsel while busy, else 0 (combinational from gsel/busy/din)
timeout  output  1  registered; 1-cycle pulse on a forced release (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. At the next posedge with reset=1: gnt=0, gsel=0, busy=0, start=0, timeout=0, ptr=0, state=IDLE, cnt=0. Reset overrides everything, including a grant in progress; there is no completion handshake for an aborted grant.
- Internal state: state ∈ {IDLE, GRANT}; ptr (2 bits) = highest-priority index; cnt (8 bits, only with the feature).
- Pick function: scan indices ptr, ptr+1, ptr+2, ptr+3, wrapping mod 4. The first i with req[i]=1 wins.
- Transitions out of IDLE:
  - If any req is set at edge N: state=GRANT, gnt=onehot(win), gsel=win, busy=1, start=1 from cycle N+1. Request-to-grant latency is 1 cycle.
  - If req=0: stay in IDLE. done is ignored in IDLE.
- Release condition in GRANT: rel = done | ~req[gsel] (requester withdrew) | forced timeout.
- In GRANT with rel=0: hold gnt, gsel and busy; start=0. Changes on other req bits are ignored.
- In GRANT with rel=1:
  - ptr <= gsel+1 (mod 4).
  - Re-arbitrate in the same edge using the new ptr and the current req, with the releasing requester included at lowest priority.
  - If a winner exists: new grant next cycle with start=1. Back-to-back grants have no idle cycle, and the same requester may be re-granted if it is the only requester.
  - Else: IDLE, and gnt, busy and gsel go to 0 next cycle.
- start is high for exactly one cycle per grant, including back-to-back grants.
- gnt is always 0 or one-hot. busy = |gnt.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - cnt clears to 0 on every new grant and increments each GRANT cycle.
  - If cnt==TIMEOUT-1 and neither done nor req drop occurs, the release is forced. A grant therefore lasts at most TIMEOUT cycles.
  - timeout=1 for one cycle, coincident with the cycle after release (the new grant's first cycle, or the first IDLE cycle).
  - ptr advances exactly as for a normal release.
  - A natural release in the same cycle takes precedence, and timeout stays 0.
- Undefined: no counter is built, grants last indefinitely, and the timeout port is constant 0.

Test Plan:
1. Hold reset=1 for 2 cycles with req=1111 -> gnt=0, busy=0, start=0, dout=0 throughout. Release reset -> gnt=0001 one cycle later.
2. req=0010 at cycle 1, din1=16'hBEEF -> cycle 2: gnt=0010, gsel=1, start=1, dout=BEEF. Cycle 3: start=0. done=1 in cycle 4 with req dropped -> cycle 5: gnt=0, busy=0, dout=0.
3. req=1111 held, done pulsed every 2nd cycle -> grant order 0,1,2,3,0. Each grant has its start pulse. No idle cycle between grants.
4. Only req[2] held, done at each grant -> consecutive grants to 2, with start=1 on every regrant. With req[2], req[3] held, a release of 2 grants 3 next.
5. Grant to 0, then req[0] drops mid-grant without done -> release next edge. With req=0100 pending -> gnt=0100.
6. Reset asserted mid-grant -> all outputs 0 next edge and ptr=0. With ARB_TIMEOUT_EN and TIMEOUT=4, a grant held with no done -> released after exactly 4 cycles and timeout=1 for one cycle.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter/sequencer for one shared resource.
// Latency: request-to-grant 1 cycle; back-to-back grants with no idle cycle on release.
// Backpressure: a grant is held until done, requester withdrawal or (optional) timeout.
//
// Ports:
//   clk, reset            - clock; synchronous active-high reset
//   req[3:0]              - request lines, bit i = requester i
//   done                  - resource finished current transaction (sampled only while busy)
//   din0..din3            - requester operands, muxed onto dout by the current grant
//   gnt, gsel, busy       - registered one-hot grant, binary index, grant-held flag
//   start                 - registered, high on the first cycle of each grant
//   dout                  - selected operand while busy, else 0 (combinational)
//   timeout               - registered one-cycle pulse after a forced release
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to TIMEOUT cycles.
// Without it, no counter is built and timeout is constant 0.

module rr_arbiter4 #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic             done,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       gnt,
  output logic [1:0]       gsel,
  output logic             busy,
  output logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic       take;       // a grant (new or back-to-back) starts next cycle
  logic [1:0] win;
  logic       rel;        // natural release: done or requester withdrew
  logic       force_rel;  // release forced by the grant-length limit
  logic [2:0] arb;        // {found, index}

  logic [3:0] gnt_nxt;
  logic [1:0] gsel_nxt;
  logic       busy_nxt;
  logic       start_nxt;
  logic       timeout_nxt;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_nxt;
`endif

  // Rotating priority scan: ptr first, then ptr+1.. wrapping mod 4.
  // Iterating from lowest priority upward lets the highest-priority hit win.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + k[1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // State register (plus registered outputs)
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt     <= 4'd0;
      gsel    <= 2'd0;
      busy    <= 1'b0;
      start   <= 1'b0;
      timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt     <= 8'd0;
`endif
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gsel    <= gsel_nxt;
      busy    <= busy_nxt;
      start   <= start_nxt;
      timeout <= timeout_nxt;
`ifdef ARB_TIMEOUT_EN
      cnt     <= cnt_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    take      = 1'b0;
    win       = 2'd0;
    rel       = 1'b0;
    force_rel = 1'b0;
    arb       = pick(req, ptr);
    case (state)
      IDLE: begin
        if (arb[2]) begin
          state_nxt = GRANT;
          take      = 1'b1;
          win       = arb[1:0];
        end
      end
      GRANT: begin
        rel = done | ~req[gsel];
`ifdef ARB_TIMEOUT_EN
        // A natural release in the same cycle wins, so no timeout pulse then.
        force_rel = ~rel & (cnt == 8'(TIMEOUT - 1));
`endif
        if (rel | force_rel) begin
          // Releasing requester sits at ptr+3, i.e. lowest priority.
          ptr_nxt = gsel + 2'd1;
          arb     = pick(req, gsel + 2'd1);
          if (arb[2]) begin
            take = 1'b1;
            win  = arb[1:0];
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    gnt_nxt     = gnt;
    gsel_nxt    = gsel;
    busy_nxt    = busy;
    start_nxt   = 1'b0;
    timeout_nxt = force_rel;
    if (take) begin
      gnt_nxt   = 4'b0001 << win;
      gsel_nxt  = win;
      busy_nxt  = 1'b1;
      start_nxt = 1'b1;
    end else if (state_nxt == IDLE) begin
      gnt_nxt  = 4'd0;
      gsel_nxt = 2'd0;
      busy_nxt = 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // cnt holds the 0-based cycle index within the current grant.
  always_comb begin
    cnt_nxt = 8'd0;
    if (!take && state_nxt == GRANT) cnt_nxt = cnt + 8'd1;
  end
`endif

  // Shared operand mux
  always_comb begin
    dout = '0;
    if (busy) begin
      case (gsel)
        2'd0:    dout = din0;
        2'd1:    dout = din1;
        2'd2:    dout = din2;
        default: dout = din3;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: each step pushes the expected post-edge grant
// onto a scoreboard queue, drives inputs, then pops and compares after the edge.
module tb_rr_arbiter4;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic        done;
  logic [15:0] din0, din1, din2, din3;
  logic [3:0]  gnt;
  logic [1:0]  gsel;
  logic        busy;
  logic        start;
  logic [15:0] dout;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] g;
    logic       s;
    logic       t;
  } exp_t;

  exp_t sb[$];

  rr_arbiter4 #(.WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .gnt(gnt), .gsel(gsel), .busy(busy), .start(start),
    .dout(dout), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic rst_i, input logic [3:0] r,
                      input logic d, input logic [3:0] eg, input logic es, input logic et);
    exp_t        e;
    logic [1:0]  eidx;
    logic        ebusy;
    logic [15:0] edout;
    e.g = eg; e.s = es; e.t = et;
    sb.push_back(e);
    reset = rst_i;
    req   = r;
    done  = d;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    case (e.g)
      4'b0010: eidx = 2'd1;
      4'b0100: eidx = 2'd2;
      4'b1000: eidx = 2'd3;
      default: eidx = 2'd0;
    endcase
    ebusy = (e.g != 4'b0000);
    case (eidx)
      2'd0:    edout = din0;
      2'd1:    edout = din1;
      2'd2:    edout = din2;
      default: edout = din3;
    endcase
    if (!ebusy) edout = 16'h0000;
    check({tag, ".gnt"},     {12'd0, gnt},     {12'd0, e.g});
    check({tag, ".gsel"},    {14'd0, gsel},    {14'd0, eidx});
    check({tag, ".busy"},    {15'd0, busy},    {15'd0, ebusy});
    check({tag, ".start"},   {15'd0, start},   {15'd0, e.s});
    check({tag, ".timeout"}, {15'd0, timeout}, {15'd0, e.t});
    check({tag, ".dout"},    dout,             edout);
  endtask

  initial begin
    din0 = 16'h1111; din1 = 16'hBEEF; din2 = 16'h2222; din3 = 16'h3333;
    reset = 1'b1; req = 4'b0000; done = 1'b0;

    // Reset held with all requests pending, then released
    step("rst_a",   1, 4'b1111, 0, 4'b0000, 0, 0);
    step("rst_b",   1, 4'b1111, 0, 4'b0000, 0, 0);
    step("rst_rel", 0, 4'b1111, 0, 4'b0001, 1, 0);
    step("rst_c",   1, 4'b0000, 0, 4'b0000, 0, 0);

    // Single request, hold, done with request dropped
    step("single_req",   0, 4'b0010, 0, 4'b0010, 1, 0);
    step("single_hold",  0, 4'b0010, 0, 4'b0010, 0, 0);
    step("single_hold2", 0, 4'b0010, 0, 4'b0010, 0, 0);
    step("single_done",  0, 4'b0000, 1, 4'b0000, 0, 0);
    step("single_idle",  0, 4'b0000, 1, 4'b0000, 0, 0);

    // All requesting, done every 2nd cycle: order 0,1,2,3,0 with no gap
    step("rr_rst",   1, 4'b0000, 0, 4'b0000, 0, 0);
    step("rr_g0",    0, 4'b1111, 0, 4'b0001, 1, 0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] cur, nxt;
      cur = 4'b0001 << k;
      nxt = 4'b0001 << ((k + 1) % 4);
      step($sformatf("rr_hold%0d", k), 0, 4'b1111, 0, cur, 0, 0);
      step($sformatf("rr_next%0d", k), 0, 4'b1111, 1, nxt, 1, 0);
    end
    step("rr_drop",  0, 4'b0000, 1, 4'b0000, 0, 0);

    // Lone requester 2 re-granted each release; then 2 releases to 3
    step("solo_g",   0, 4'b0100, 0, 4'b0100, 1, 0);
    step("solo_re1", 0, 4'b0100, 1, 4'b0100, 1, 0);
    step("solo_re2", 0, 4'b0100, 1, 4'b0100, 1, 0);
    step("solo_to3", 0, 4'b1100, 1, 4'b1000, 1, 0);
    step("solo_end", 0, 4'b0000, 1, 4'b0000, 0, 0);

    // Requester 0 withdraws mid-grant without done, 2 pending takes over
    step("wd_g0",   0, 4'b0001, 0, 4'b0001, 1, 0);
    step("wd_hold", 0, 4'b0101, 0, 4'b0001, 0, 0);
    step("wd_to2",  0, 4'b0100, 0, 4'b0100, 1, 0);
    step("wd_idle", 0, 4'b0000, 0, 4'b0000, 0, 0);

    // Reset mid-grant; pointer must restart at 0 (1 beats 3)
    step("mr_g3",   0, 4'b1000, 0, 4'b1000, 1, 0);
    step("mr_hold", 0, 4'b1000, 0, 4'b1000, 0, 0);
    step("mr_rst",  1, 4'b1000, 0, 4'b0000, 0, 0);
    step("mr_ptr0", 0, 4'b1010, 0, 4'b0010, 1, 0);

    // Grant held without done: TIMEOUT=4 forces release after 4 cycles
    step("to_h1", 0, 4'b0010, 0, 4'b0010, 0, 0);
    step("to_h2", 0, 4'b0010, 0, 4'b0010, 0, 0);
    step("to_h3", 0, 4'b0010, 0, 4'b0010, 0, 0);
`ifdef ARB_TIMEOUT_EN
    step("to_fire", 0, 4'b0010, 0, 4'b0010, 1, 1);
`else
    step("to_fire", 0, 4'b0010, 0, 4'b0010, 0, 0);
`endif
    step("to_post", 0, 4'b0010, 0, 4'b0010, 0, 0);
    step("to_h4",   0, 4'b0010, 0, 4'b0010, 0, 0);
    step("to_h5",   0, 4'b1010, 0, 4'b0010, 0, 0);
    // Natural release at the limit cycle: no timeout pulse
    step("to_nat",  0, 4'b1010, 1, 4'b1000, 1, 0);
    step("to_end",  0, 4'b0000, 0, 4'b0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
